// File: rtl/operand_fetch.sv
// operand_fetch: operand stage ahead of the shifter/ALU.
//   Holds an NREGS x DATA_W register file with one write port and one shared
//   read port. A request reads Rn into operand A, then Rm into operand B, on
//   two consecutive cycles, then presents A, B and the shift code downstream.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_rn, req_rm, req_shift         operand indices and shift code
//   wr_en, wr_addr, wr_data           register write port (any state)
//   out_valid/out_ready               operand handshake
//   out_a, out_b, out_shift           operands (B feeds the shifter)
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rn,
    input  logic [ADDR_W-1:0] req_rm,
    input  logic [1:0]        req_shift,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [1:0]        out_shift
);

    typedef enum logic [1:0] {IDLE, READ_A, READ_B, PRESENT} state_t;

    state_t                        state;
    logic [NREGS-1:0][DATA_W-1:0]  regs;
    logic [ADDR_W-1:0]             rn_q, rm_q;
    logic [1:0]                    shift_q;
    logic [ADDR_W-1:0]             rd_addr;
    logic [DATA_W-1:0]             rd_data;

    assign req_ready = (state == IDLE);

    // Single read port: Rn in READ_A, Rm otherwise (only used in READ_B).
    assign rd_addr = (state == READ_A) ? rn_q : rm_q;

    // A write landing on the same edge as the read wins over the old value.
    assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : regs[rd_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            regs      <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            shift_q   <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_shift <= '0;
            out_valid <= 1'b0;
        end else begin
            if (wr_en) regs[wr_addr] <= wr_data;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rn_q    <= req_rn;
                        rm_q    <= req_rm;
                        shift_q <= req_shift;
                        state   <= READ_A;
                    end
                end
                READ_A: begin
                    out_a <= rd_data;
                    state <= READ_B;
                end
                READ_B: begin
                    out_b     <= rd_data;
                    out_shift <= shift_q;
                    out_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    // Outputs only change in READ_A/READ_B, so they hold here.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: scoreboard plus reference model.
module tb_operand_fetch;
    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rn = '0, req_rm = '0;
    logic [1:0]        req_shift = '0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_a, out_b;
    logic [1:0]        out_shift;

    operand_fetch #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rn(req_rn), .req_rm(req_rm), .req_shift(req_shift),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_shift(out_shift)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // age = edges since the request was accepted (0 = no request in flight).
    // A is the register value as it stands after the 1st edge following
    // accept (a same-edge write counts), B likewise after the 2nd edge; the
    // operands are then offered from the 3rd edge until taken.
    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [1:0]        sh;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] mreg[NREGS];
    int                age = 0;
    logic [ADDR_W-1:0] m_rn, m_rm;
    logic [1:0]        m_sh;
    logic [DATA_W-1:0] m_a;
    bit                mon_en = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mreg[i] = '0;
            age = 0;
            exp_q.delete();
        end else begin
            if (wr_en) mreg[wr_addr] = wr_data;
            if (age == 0) begin
                if (req_valid) begin
                    m_rn = req_rn; m_rm = req_rm; m_sh = req_shift;
                    age = 1;
                end
            end else if (age == 1) begin
                m_a = mreg[m_rn];
                age = 2;
            end else if (age == 2) begin
                exp_q.push_back('{a: m_a, b: mreg[m_rm], sh: m_sh});
                age = 3;
            end else if (out_ready) begin
                age = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("req_ready", req_ready, age == 0);
            chk("out_valid", out_valid, age == 3);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 0, 1);
                end else begin
                    chk("operands", {out_a, out_b, out_shift},
                        {exp_q[0].a, exp_q[0].b, exp_q[0].sh});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Returns just after the accepting edge.
    task automatic do_req(input logic [ADDR_W-1:0] rn, input logic [ADDR_W-1:0] rm,
                          input logic [1:0] sh);
        bit ok;
        ok = 0;
        req_valid = 1'b1; req_rn = rn; req_rm = rm; req_shift = sh;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        chk("req_accept_timeout", ok, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Returns on the negedge where out_valid is seen.
    task automatic wait_valid();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        chk("out_valid_timeout", ok, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int hs[$];
        // Reset held 2 edges with a write pending; the write must be ignored.
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = '0; wr_data = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_shift", out_shift, 0);
        mon_en = 1;

        out_ready = 1'b1;
        do_req(0, 0, 2'b10);
        wait_valid();
        chk("rst_r0_a", out_a, 0);
        chk("rst_r0_b", out_b, 0);

        // Basic fetch
        write_reg(2, 16'h1234);
        write_reg(5, 16'h8001);
        do_req(2, 5, 2'b11);
        @(negedge clk); chk("lat_e1_valid", out_valid, 0);
        @(negedge clk); chk("lat_e2_valid", out_valid, 0);
        @(negedge clk); chk("lat_e3_valid", out_valid, 1);
        chk("basic_a", out_a, 16'h1234);
        chk("basic_b", out_b, 16'h8001);
        chk("basic_shift", out_shift, 2'b11);
        @(negedge clk);
        chk("basic_pulse_end", out_valid, 0);
        chk("basic_ready_back", req_ready, 1);

        // Bypass: write r3 only on the READ_B edge
        write_reg(3, 16'h0000);
        do_req(3, 3, 2'b00);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 3; wr_data = 16'hBEEF;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_valid();
        chk("bypass_a", out_a, 16'h0000);
        chk("bypass_b", out_b, 16'hBEEF);

        // Backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_req(2, 5, 2'b01);
        wait_valid();
        wr_en = 1'b1; wr_addr = 2; wr_data = 16'hFFFF;
        req_valid = 1'b1; req_rn = 1; req_rm = 1; req_shift = 2'b00;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_a", out_a, 16'h1234);
            chk("bp_b", out_b, 16'h8001);
            chk("bp_ready", req_ready, 0);
        end
        wr_en = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", req_ready, 1);

        // Reset in READ_B
        do_req(2, 5, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", req_ready, 1);
        repeat (4) begin
            chk("midrst_no_pulse", out_valid, 0);
            @(negedge clk);
        end
        do_req(2, 5, 2'b00);
        wait_valid();
        chk("midrst_r2", out_a, 0);
        chk("midrst_r5", out_b, 0);

        // Back-to-back with req_valid held
        @(posedge clk); #1;
        req_valid = 1'b1; req_rn = 5; req_rm = 2; req_shift = 2'b10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs.push_back(c);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_count", hs.size() >= 2, 1);
        if (hs.size() >= 2) chk("b2b_spacing", hs[1] - hs[0], 4);

        // Randomized traffic
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 600; i++) begin
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_addr   = ADDR_W'($urandom_range(0, NREGS - 1));
            wr_data   = DATA_W'($urandom);
            req_valid = $urandom_range(0, 1);
            req_rn    = ADDR_W'($urandom_range(0, NREGS - 1));
            req_rm    = ADDR_W'($urandom_range(0, NREGS - 1));
            req_shift = 2'($urandom_range(0, 3));
            out_ready = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        wr_en = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
